// File: rtl/vga_timing_gen_pkg.sv
// Shared definitions for the VGA timing generator: phase encoding,
// standard 640x480@60 default timings and a small sizing helper.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        PH_DISP  = 2'd0,
        PH_FRONT = 2'd1,
        PH_SYNC  = 2'd2,
        PH_BACK  = 2'd3
    } phase_e;

    localparam int DEF_H_DISP  = 640;
    localparam int DEF_H_FRONT = 16;
    localparam int DEF_H_SYNC  = 96;
    localparam int DEF_H_BACK  = 48;
    localparam int DEF_V_DISP  = 480;
    localparam int DEF_V_FRONT = 10;
    localparam int DEF_V_SYNC  = 2;
    localparam int DEF_V_BACK  = 33;
    localparam int DEF_CW      = 12;

    // Total period of one axis (pixels per line or lines per frame).
    function automatic int axis_total(input int disp, input int front,
                                      input int sync, input int back);
        return disp + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle: sync levels, display enable, active coordinates
// and line/frame start strobes. The generator drives it as master.
interface vga_timing_gen_if #(
    parameter int CW = 12
);
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          line_start;
    logic          frame_start;

    modport master (
        output hsync, vsync, de, x, y, line_start, frame_start
    );

    modport slave (
        input hsync, vsync, de, x, y, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen_axis.sv
// One timing axis: a wrapping position counter plus its phase decode
// (display, front porch, sync, back porch) and the sync level.
module axis_timing
    import vga_timing_pkg::*;
#(
    parameter int DISP  = DEF_H_DISP,
    parameter int FRONT = DEF_H_FRONT,
    parameter int SYNC  = DEF_H_SYNC,
    parameter int BACK  = DEF_H_BACK,
    parameter int POL   = 0,
    parameter int CW    = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          adv,
    output logic [CW-1:0] cnt,
    output phase_e        phase,
    output logic          sync,
    output logic          wrap
);

    localparam int            TOTAL    = axis_total(DISP, FRONT, SYNC, BACK);
    localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
    localparam logic [CW-1:0] FRONT_AT = CW'(DISP);
    localparam logic [CW-1:0] SYNC_AT  = CW'(DISP + FRONT);
    localparam logic [CW-1:0] BACK_AT  = CW'(DISP + FRONT + SYNC);
    localparam logic          ACT      = 1'(POL);

    // Every phase must exist and the period must fit in the counter.
    if (DISP < 1 || FRONT < 1 || SYNC < 1 || BACK < 1) begin : g_bad_phase
        $error("axis_timing: every phase length must be at least 1");
    end
    if (TOTAL > (1 << CW)) begin : g_bad_width
        $error("axis_timing: axis total does not fit in CW bits");
    end

    // Terminal count: the next advance returns the counter to 0.
    assign wrap = (cnt == LAST);

    // Position counter, advances only when told to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     cnt <= '0;
        else if (adv) cnt <= wrap ? '0 : cnt + CW'(1);
    end

    // Phase decode from the raw count; phases are contiguous in order.
    always_comb begin
        phase = PH_BACK;
        if (cnt < FRONT_AT)     phase = PH_DISP;
        else if (cnt < SYNC_AT) phase = PH_FRONT;
        else if (cnt < BACK_AT) phase = PH_SYNC;
    end

    assign sync = (phase == PH_SYNC) ? ACT : ~ACT;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: horizontal and vertical axes chained so that the
// vertical counter steps on each horizontal wrap, with all outputs
// registered one ce-qualified cycle behind the counters they decode.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISP  = DEF_H_DISP,
    parameter int H_FRONT = DEF_H_FRONT,
    parameter int H_SYNC  = DEF_H_SYNC,
    parameter int H_BACK  = DEF_H_BACK,
    parameter int V_DISP  = DEF_V_DISP,
    parameter int V_FRONT = DEF_V_FRONT,
    parameter int V_SYNC  = DEF_V_SYNC,
    parameter int V_BACK  = DEF_V_BACK,
    parameter int H_POL   = 0,
    parameter int V_POL   = 0,
    parameter int CW      = DEF_CW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    vga_timing_gen_if.master  vid
);

    localparam logic H_ACT = 1'(H_POL);
    localparam logic V_ACT = 1'(V_POL);

    logic [CW-1:0] hcnt, vcnt;
    phase_e        h_phase, v_phase;
    logic          h_sync, v_sync;
    logic          h_wrap, unused_v_wrap;
    logic          v_adv;
    logic          de_next;

    // Vertical steps once per line, on the pixel that ends the line.
    assign v_adv = h_wrap & ce;

    axis_timing #(
        .DISP(H_DISP), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
        .POL(H_POL), .CW(CW)
    ) u_h (
        .clk(clk), .rst(rst), .adv(ce),
        .cnt(hcnt), .phase(h_phase), .sync(h_sync), .wrap(h_wrap)
    );

    axis_timing #(
        .DISP(V_DISP), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
        .POL(V_POL), .CW(CW)
    ) u_v (
        .clk(clk), .rst(rst), .adv(v_adv),
        .cnt(vcnt), .phase(v_phase), .sync(v_sync), .wrap(unused_v_wrap)
    );

    assign de_next = (h_phase == PH_DISP) && (v_phase == PH_DISP);

    // Output register: captures the decode of the current position on a
    // ce edge; strobes are dropped on any non-ce clock so they last one clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vid.hsync       <= ~H_ACT;
            vid.vsync       <= ~V_ACT;
            vid.de          <= 1'b0;
            vid.x           <= '0;
            vid.y           <= '0;
            vid.line_start  <= 1'b0;
            vid.frame_start <= 1'b0;
        end else if (ce) begin
            vid.hsync       <= h_sync;
            vid.vsync       <= v_sync;
            vid.de          <= de_next;
            vid.x           <= de_next ? hcnt : '0;
            vid.y           <= de_next ? vcnt : '0;
            vid.line_start  <= (hcnt == '0);
            vid.frame_start <= (hcnt == '0) && (vcnt == '0);
        end else begin
            vid.line_start  <= 1'b0;
            vid.frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a 29x29 test raster (15/1/3/10 per axis).
// Two instances share clk/rst/ce: active-low syncs and active-high syncs.
module tb_vga_timing_gen;

    localparam int HD = 15, HF = 1, HS = 3, HB = 10;
    localparam int HT = HD + HF + HS + HB;   // 29
    localparam int VD = 15, VF = 1, VS = 3, VB = 10;
    localparam int VT = VD + VF + VS + VB;   // 29
    localparam int FT = HT * VT;             // 841

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce  = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.CW(6)) vif0 ();
    vga_timing_gen_if #(.CW(6)) vif1 ();

    vga_timing_gen #(
        .H_DISP(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISP(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_POL(0), .V_POL(0), .CW(6)
    ) dut0 (.clk(clk), .rst(rst), .ce(ce), .vid(vif0));

    vga_timing_gen #(
        .H_DISP(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISP(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_POL(1), .V_POL(1), .CW(6)
    ) dut1 (.clk(clk), .rst(rst), .ce(ce), .vid(vif1));

    logic [16:0] act0, act1;
    assign act0 = {vif0.hsync, vif0.vsync, vif0.de, vif0.x, vif0.y,
                   vif0.line_start, vif0.frame_start};
    assign act1 = {vif1.hsync, vif1.vsync, vif1.de, vif1.x, vif1.y,
                   vif1.line_start, vif1.frame_start};

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int pos    = -1;   // raster index currently presented, -1 = reset state
    bit pulse  = 0;    // last clock edge was a ce edge

    // Reference: what the outputs should show for raster index p.
    function automatic logic [16:0] model(input int p, input bit pl, input bit pol);
        int h, v;
        logic hs, vs, de;
        if (p < 0) return {~pol, ~pol, 15'd0};
        h  = p % HT;
        v  = p / HT;
        de = (h < HD) && (v < VD);
        hs = (h >= HD + HF && h < HD + HF + HS) ? pol : ~pol;
        vs = (v >= VD + VF && v < VD + VF + VS) ? pol : ~pol;
        return {hs, vs, de, de ? 6'(h) : 6'd0, de ? 6'(v) : 6'd0,
                pl && (h == 0), pl && (h == 0) && (v == 0)};
    endfunction

    // One clock with the given ce, advancing the reference raster position.
    task automatic tick(input bit ce_v);
        ce = ce_v;
        @(posedge clk);
        cyc++;
        if (rst) begin
            if (ce_v) begin
                pos   = (pos + 1) % FT;
                pulse = 1;
            end else begin
                pulse = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        pos = -1; pulse = 0;
        #1;
        n_chk++;
        if (act0 !== model(-1, 0, 0)) begin
            n_fail++; $display("FAIL reset_async_pol0: got %h want %h", act0, model(-1, 0, 0));
        end
        n_chk++;
        if (act1 !== model(-1, 0, 1)) begin
            n_fail++; $display("FAIL reset_async_pol1: got %h want %h", act1, model(-1, 0, 1));
        end
        for (int i = 0; i < 3; i++) tick(1);
        n_chk++;
        if (act0 !== model(-1, 0, 0)) begin
            n_fail++; $display("FAIL reset_held: got %h want %h", act0, model(-1, 0, 0));
        end
    endtask

    task automatic test_periods;
        int last_ls, last_fs, n_fs;
        last_ls = -1; last_fs = -1; n_fs = 0;
        rst = 1'b1;
        cyc = 0;
        for (int i = 0; i < 1700; i++) begin
            tick(1);
            if (vif0.line_start) begin
                n_chk++;
                if (last_ls < 0 ? (cyc != 1) : (cyc - last_ls != HT)) begin
                    n_fail++; $display("FAIL line_period: at cyc %0d prev %0d want period %0d", cyc, last_ls, HT);
                end
                last_ls = cyc;
            end
            if (vif0.frame_start) begin
                n_chk++;
                if (last_fs < 0 ? (cyc != 1) : (cyc - last_fs != FT)) begin
                    n_fail++; $display("FAIL frame_period: at cyc %0d prev %0d want period %0d", cyc, last_fs, FT);
                end
                last_fs = cyc;
                n_fs++;
            end
        end
        n_chk++;
        if (n_fs != 3) begin
            n_fail++; $display("FAIL frame_count: got %0d want 3", n_fs);
        end
    endtask

    task automatic test_steady;
        int n_de, n_hs, n_vs, n_bad;
        n_de = 0; n_hs = 0; n_vs = 0; n_bad = 0;
        for (int i = 0; i < FT; i++) begin
            tick(1);
            n_de += int'(vif0.de);
            n_hs += int'(!vif0.hsync);
            n_vs += int'(!vif0.vsync);
            if (act0 !== model(pos, pulse, 0) || act1 !== model(pos, pulse, 1)) begin
                n_bad++;
                if (n_bad < 5)
                    $display("FAIL steady pos %0d: got %h/%h want %h/%h", pos, act0, act1,
                             model(pos, pulse, 0), model(pos, pulse, 1));
            end
        end
        n_chk++;
        if (n_bad != 0) begin
            n_fail++; $display("FAIL steady_summary: %0d bad cycles, want 0", n_bad);
        end
        n_chk++;
        if (n_de != HD * VD) begin
            n_fail++; $display("FAIL de_count: got %0d want %0d", n_de, HD * VD);
        end
        n_chk++;
        if (n_hs != HS * VT) begin
            n_fail++; $display("FAIL hsync_count: got %0d want %0d", n_hs, HS * VT);
        end
        n_chk++;
        if (n_vs != VS * HT) begin
            n_fail++; $display("FAIL vsync_count: got %0d want %0d", n_vs, VS * HT);
        end
    endtask

    task automatic test_ce_third;
        logic [16:0] prev;
        int last_ls, n_bad;
        last_ls = -1; n_bad = 0;
        for (int i = 0; i < 2 * FT * 3; i++) begin
            prev = act0;
            tick(i % 3 == 0);
            if (act0 !== model(pos, pulse, 0)) n_bad++;
            if (!pulse && act0[16:2] !== prev[16:2]) n_bad++;
            if (vif0.line_start) begin
                if (last_ls >= 0) begin
                    n_chk++;
                    if (cyc - last_ls != 3 * HT) begin
                        n_fail++; $display("FAIL ce3_line_period: got %0d want %0d", cyc - last_ls, 3 * HT);
                    end
                end
                last_ls = cyc;
            end
        end
        n_chk++;
        if (n_bad != 0) begin
            n_fail++; $display("FAIL ce3_cycles: %0d bad cycles, want 0", n_bad);
        end
    endtask

    task automatic test_ce_random;
        int n_bad;
        n_bad = 0;
        for (int i = 0; i < 3000; i++) begin
            tick(1'($urandom_range(0, 1)));
            if (act0 !== model(pos, pulse, 0) || act1 !== model(pos, pulse, 1)) begin
                n_bad++;
                if (n_bad < 5)
                    $display("FAIL ce_rand pos %0d: got %h want %h", pos, act0, model(pos, pulse, 0));
            end
        end
        n_chk++;
        if (n_bad != 0) begin
            n_fail++; $display("FAIL ce_rand_summary: %0d bad cycles, want 0", n_bad);
        end
    endtask

    task automatic test_reset_mid;
        int target, guard;
        target = 7 * HT + 20;
        guard  = 0;
        while (pos != target && guard < 2 * FT) begin
            tick(1);
            guard++;
        end
        n_chk++;
        if (pos != target) begin
            n_fail++; $display("FAIL mid_reach: got pos %0d want %0d", pos, target);
        end
        #3 rst = 1'b0;
        pos = -1; pulse = 0;
        #1;
        n_chk++;
        if (act0 !== model(-1, 0, 0) || act1 !== model(-1, 0, 1)) begin
            n_fail++; $display("FAIL mid_reset_async: got %h/%h want %h/%h", act0, act1,
                               model(-1, 0, 0), model(-1, 0, 1));
        end
        tick(1);
        tick(1);
        rst = 1'b1;
        tick(1);
        n_chk++;
        if ({vif0.frame_start, vif0.line_start, vif0.de} !== 3'b111) begin
            n_fail++; $display("FAIL restart_strobes: got %b want 111",
                               {vif0.frame_start, vif0.line_start, vif0.de});
        end
        n_chk++;
        if (act0 !== model(0, 1, 0) || act1 !== model(0, 1, 1)) begin
            n_fail++; $display("FAIL restart_vec: got %h/%h want %h/%h", act0, act1,
                               model(0, 1, 0), model(0, 1, 1));
        end
        tick(0);
        n_chk++;
        if (vif0.frame_start !== 1'b0 || vif0.line_start !== 1'b0) begin
            n_fail++; $display("FAIL restart_pulse_width: got fs=%b ls=%b want 0 0",
                               vif0.frame_start, vif0.line_start);
        end
    endtask

    initial begin
        test_reset;
        test_periods;
        test_steady;
        test_ce_third;
        test_ce_random;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
